// File: rtl/i2c_eeprom_responder.sv
// I2C target emulating a 16x8 serial EEPROM, sampling the bus on CLK.
// Optional write protect: define EEPROM_WP_EN to add the synchronized WP input.
module i2c_eeprom_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       CLK,
    input  logic       RESET_N,
`ifdef EEPROM_WP_EN
    input  logic       WP,
`endif
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       BUSY,
    output logic       WR_STROBE,
    output logic [7:0] WR_BYTE,
    output logic [3:0] WR_ADDR
);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, WORD, WORD_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP
    } state_t;

    state_t     state;
    logic       scl_p0, scl_p1, scl_p2;
    logic       sda_p0, sda_p1, sda_p2;
    logic [7:0] shift;
    logic [3:0] cnt;
    logic [3:0] ptr;
    logic [3:0] ptr_next;
    logic [7:0] mem [16];
    logic       sda_low;
    logic       ack_bit;
    logic       wr_block;
    logic       scl_rise, scl_fall, start_det, stop_det;

    // Open-drain: only ever pull low, so reset releases the line at once.
    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign start_det = scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
    assign stop_det  = scl_p1 & scl_p2 & sda_p1 & ~sda_p2;
    assign ptr_next  = ptr + 4'd1;

`ifdef EEPROM_WP_EN
    logic wp_p0, wp_p1, wp_hit;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wp_p0 <= 1'b0;
            wp_p1 <= 1'b0;
        end else begin
            wp_p0 <= WP;
            wp_p1 <= wp_p0;
        end
    end

    // WP level seen on the 8th data bit decides whether the byte is refused.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            wp_hit <= 1'b0;
        else if (state == WR && scl_rise && cnt == 4'd7)
            wp_hit <= wp_p1;
    end

    assign wr_block = wp_hit;
`else
    assign wr_block = 1'b0;
`endif

    // Bus synchronizers idle high so reset release never fakes an edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
            sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= I2C_SCLK; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
            sda_p0 <= I2C_SDAT; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            shift     <= 8'h00;
            cnt       <= 4'd0;
            ptr       <= 4'd0;
            sda_low   <= 1'b0;
            ack_bit   <= 1'b1;
            BUSY      <= 1'b0;
            WR_STROBE <= 1'b0;
            WR_BYTE   <= 8'h00;
            WR_ADDR   <= 4'h0;
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else begin
            WR_STROBE <= 1'b0;
            if (stop_det) begin
                state   <= IDLE;
                sda_low <= 1'b0;
                BUSY    <= 1'b0;
            end else if (start_det) begin
                state   <= DEV;
                cnt     <= 4'd0;
                sda_low <= 1'b0;
            end else begin
                case (state)
                    DEV: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda_p1};
                            cnt   <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            if (shift[7:1] == DEV_ADDR) begin
                                state   <= DEV_ACK;
                                sda_low <= 1'b1;
                                BUSY    <= 1'b1;
                            end else begin
                                state   <= WAIT_STOP;
                                sda_low <= 1'b0;
                                BUSY    <= 1'b0;
                            end
                        end
                    end
                    DEV_ACK: begin
                        if (scl_fall) begin
                            cnt <= 4'd0;
                            if (shift[0]) begin
                                state   <= RD;
                                shift   <= mem[ptr];
                                sda_low <= ~mem[ptr][7];
                            end else begin
                                state   <= WORD;
                                sda_low <= 1'b0;
                            end
                        end
                    end
                    WORD: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda_p1};
                            cnt   <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            ptr     <= shift[3:0];
                            state   <= WORD_ACK;
                            sda_low <= 1'b1;
                        end
                    end
                    WORD_ACK: begin
                        if (scl_fall) begin
                            state   <= WR;
                            cnt     <= 4'd0;
                            sda_low <= 1'b0;
                        end
                    end
                    WR: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda_p1};
                            cnt   <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            if (wr_block) begin
                                state   <= WAIT_STOP;
                                sda_low <= 1'b0;
                            end else begin
                                state   <= WR_ACK;
                                sda_low <= 1'b1;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            mem[ptr]  <= shift;
                            WR_STROBE <= 1'b1;
                            WR_BYTE   <= shift;
                            WR_ADDR   <= ptr;
                            ptr       <= ptr_next;
                            cnt       <= 4'd0;
                            sda_low   <= 1'b0;
                            state     <= WR;
                        end
                    end
                    RD: begin
                        // Bit 7 was put out on entry; each later fall shifts the next bit out.
                        if (scl_rise) begin
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (cnt == 4'd8) begin
                                state   <= RD_ACK;
                                sda_low <= 1'b0;
                            end else begin
                                shift   <= {shift[6:0], 1'b0};
                                sda_low <= ~shift[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            ack_bit <= sda_p1;
                        end else if (scl_fall) begin
                            if (!ack_bit) begin
                                ptr     <= ptr_next;
                                shift   <= mem[ptr_next];
                                sda_low <= ~mem[ptr_next][7];
                                cnt     <= 4'd0;
                                state   <= RD;
                            end else begin
                                state   <= WAIT_STOP;
                                sda_low <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// Directed bench for i2c_eeprom_responder: bit-banged I2C master with hand-computed expectations.
module tb_i2c_eeprom_responder;

    localparam int Q = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    wire        sda_bus;
    logic       busy, wr_strobe;
    logic [7:0] wr_byte;
    logic [3:0] wr_addr;
    int         total = 0;
    int         bad = 0;
    int         strobes = 0;
    logic       ack;
    logic [7:0] rd;
`ifdef EEPROM_WP_EN
    logic       wp = 1'b0;
`endif

    pullup (sda_bus);
    assign sda_bus = m_sda ? 1'bz : 1'b0;

    i2c_eeprom_responder #(.DEV_ADDR(7'h50)) dut (
        .CLK(clk),
        .RESET_N(rst_n),
`ifdef EEPROM_WP_EN
        .WP(wp),
`endif
        .I2C_SCLK(scl),
        .I2C_SDAT(sda_bus),
        .BUSY(busy),
        .WR_STROBE(wr_strobe),
        .WR_BYTE(wr_byte),
        .WR_ADDR(wr_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_strobe === 1'b1) strobes++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wbit(input logic b);
        m_sda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(a);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack);
    endtask

    initial begin
        #23;
        chk("rst_sda", sda_bus, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_byte", wr_byte, 8'h00);
        chk("rst_addr", wr_addr, 4'h0);
        @(negedge clk); rst_n = 1'b1;
        #(4*Q);

        // write 0x55 to location 3
        i2c_start();
        send_byte(8'hA0, ack); chk("wr_dev_ack", ack, 1'b0);
        chk("wr_busy", busy, 1'b1);
        send_byte(8'h03, ack); chk("wr_word_ack", ack, 1'b0);
        send_byte(8'h55, ack); chk("wr_data_ack", ack, 1'b0);
        i2c_stop(); #Q;
        chk("wr_strobes", strobes, 1);
        chk("wr_addr", wr_addr, 4'h3);
        chk("wr_byte", wr_byte, 8'h55);
        chk("wr_busy_end", busy, 1'b0);

        // random read of location 3 via repeated start
        i2c_start();
        send_byte(8'hA0, ack); chk("rd_dev_ack", ack, 1'b0);
        send_byte(8'h03, ack); chk("rd_word_ack", ack, 1'b0);
        i2c_start();
        send_byte(8'hA1, ack); chk("rd_dev1_ack", ack, 1'b0);
        recv_byte(rd, 1'b1); chk("rd_data", rd, 8'h55);
        i2c_stop(); #Q;
        chk("rd_busy_end", busy, 1'b0);

        // foreign address is ignored
        i2c_start();
        send_byte(8'hA4, ack); chk("mis_ack", ack, 1'b1);
        chk("mis_busy", busy, 1'b0);
        send_byte(8'h12, ack); chk("mis_data_ack", ack, 1'b1);
        i2c_stop(); #Q;
        chk("mis_strobes", strobes, 1);

        // pointer wrap 15 -> 0 on write and read
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack);
        send_byte(8'hAA, ack); chk("wrap_w0_ack", ack, 1'b0);
        send_byte(8'h11, ack); chk("wrap_w1_ack", ack, 1'b0);
        send_byte(8'h22, ack); chk("wrap_w2_ack", ack, 1'b0);
        i2c_stop(); #Q;
        chk("wrap_strobes", strobes, 4);
        chk("wrap_addr", wr_addr, 4'h1);
        chk("wrap_byte", wr_byte, 8'h22);
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        recv_byte(rd, 1'b0); chk("wrap_r0", rd, 8'hAA);
        recv_byte(rd, 1'b0); chk("wrap_r1", rd, 8'h11);
        recv_byte(rd, 1'b1); chk("wrap_r2", rd, 8'h22);
        i2c_stop(); #Q;

        // STOP after 4 data bits: byte dropped, pointer kept at 5
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack);
        send_byte(8'hC3, ack);
        i2c_stop(); #Q;
        chk("abort_pre_strobes", strobes, 5);
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        i2c_stop(); #Q;
        chk("abort_strobes", strobes, 5);
        chk("abort_busy", busy, 1'b0);
        i2c_start();
        send_byte(8'hA1, ack); chk("abort_dev_ack", ack, 1'b0);
        recv_byte(rd, 1'b1); chk("abort_ptr_data", rd, 8'hC3);
        i2c_stop(); #Q;

        // reset while the responder pulls SDA low for a data bit
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        chk("mid_sda_low", sda_bus, 1'b0);
        chk("mid_busy", busy, 1'b1);
        #3; rst_n = 1'b0; #1;
        chk("mid_rst_sda", sda_bus, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_byte", wr_byte, 8'h00);
        chk("mid_rst_addr", wr_addr, 4'h0);
        chk("mid_rst_strobe", wr_strobe, 1'b0);
        #20; @(negedge clk); rst_n = 1'b1;
        i2c_stop(); #Q;
        i2c_start();
        send_byte(8'hA0, ack); chk("post_rst_ack", ack, 1'b0);
        send_byte(8'h03, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        recv_byte(rd, 1'b1); chk("post_rst_mem", rd, 8'h00);
        i2c_stop(); #Q;

`ifdef EEPROM_WP_EN
        // write protect refuses the data byte only
        wp = 1'b1;
        strobes = 0;
        i2c_start();
        send_byte(8'hA0, ack); chk("wp_dev_ack", ack, 1'b0);
        send_byte(8'h02, ack); chk("wp_word_ack", ack, 1'b0);
        send_byte(8'h77, ack); chk("wp_data_nack", ack, 1'b1);
        i2c_stop(); #Q;
        wp = 1'b0;
        chk("wp_strobes", strobes, 0);
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h02, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        recv_byte(rd, 1'b1); chk("wp_mem", rd, 8'h00);
        i2c_stop(); #Q;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
